// File: rtl/mips_rf_pkg.sv
// Shared types and defaults for the MIPS multi-port register file and its scoreboard.
package mips_rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // $zero: hardwired to 0, never written, never pending
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register pending-write bits: a set from a newly issued load beats a clear from a completing write.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pending
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
        pend_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (pend_set && pend_addr != ADDR_W'(ZERO_REG))
      pend_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_lookup
    assign rd_pending[j] = pend_q[rd_addr[j*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/mips_reg_file_mp.sv
// Parametrised multi-port MIPS GPR file with HI/LO and pending-load scoreboard.
// Define MIPS_RF_BYPASS_EN to forward same-cycle write data to the read ports and HI/LO outputs.
module mips_reg_file_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        RegWrite,
  input  logic [NUM_WR*ADDR_W-1:0] WriteAddress,
  input  logic [NUM_WR*DATA_W-1:0] DataIn,
  input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
  output logic [NUM_RD*DATA_W-1:0] DataOut,
  output logic [NUM_RD-1:0]        ReadPending,
  input  logic                     PendSet,
  input  logic [ADDR_W-1:0]        PendAddress,
  input  logic                     HiLoWrite,
  input  logic [DATA_W-1:0]        HiIn,
  input  logic [DATA_W-1:0]        LoIn,
  output logic [DATA_W-1:0]        HiOut,
  output logic [DATA_W-1:0]        LoOut
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [NUM_RD-1:0] pend_raw;

  // Ascending port order: the highest-index port writing an address lands last and wins
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (RegWrite[k] && WriteAddress[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
        regs_d[WriteAddress[k*ADDR_W +: ADDR_W]] = DataIn[k*DATA_W +: DATA_W];
    end
    regs_d[ZERO_REG] = '0;
  end

  always_comb begin
    hi_d = HiLoWrite ? HiIn : hi_q;
    lo_d = HiLoWrite ? LoIn : lo_q;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      regs_q <= '{default: '0};
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  mips_rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (rst),
    .pend_set   (PendSet),
    .pend_addr  (PendAddress),
    .wr_en      (RegWrite),
    .wr_addr    (WriteAddress),
    .rd_addr    (ReadAddress),
    .rd_pending (pend_raw)
  );

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign ra = ReadAddress[j*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[ra];
      pend = pend_raw[j];
`ifdef MIPS_RF_BYPASS_EN
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (RegWrite[k] && WriteAddress[k*ADDR_W +: ADDR_W] == ra) begin
          data = rst ? '0 : DataIn[k*DATA_W +: DATA_W];
          pend = 1'b0;
        end
      end
`endif
      if (ra == ADDR_W'(ZERO_REG)) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign DataOut[j*DATA_W +: DATA_W] = data;
    assign ReadPending[j]              = pend;
  end

  always_comb begin
`ifdef MIPS_RF_BYPASS_EN
    HiOut = HiLoWrite ? (rst ? '0 : HiIn) : hi_q;
    LoOut = HiLoWrite ? (rst ? '0 : LoIn) : lo_q;
`else
    HiOut = hi_q;
    LoOut = lo_q;
`endif
  end

endmodule

// File: doc/mips_reg_file_mp.md
Name: mips_reg_file_mp

Overview:
- Parametrised multi-port MIPS general-purpose register file. Successor to the fixed 2-read/1-write 32x32 file.
- Generalised in data width, depth, and read/write port count.
- Adds architectural HI/LO registers for MULT/DIV results.
- Adds a per-register pending-write scoreboard so the issue stage can stall on outstanding multi-cycle loads.
- Sits in the decode stage. Reads are combinational; writes happen at the writeback edge.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth NREGS = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- NUM_WR, 1, number of write ports (1..2); port index is the write priority (higher wins).

Ports:
- CLK  in  1  sole clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  NUM_WR  per-port write enable.
- WriteAddress  in  NUM_WR*ADDR_W  packed write addresses; port k at bits [k*ADDR_W +: ADDR_W].
- DataIn  in  NUM_WR*DATA_W  packed write data.
- ReadAddress  in  NUM_RD*ADDR_W  packed read addresses.
- DataOut  out  NUM_RD*DATA_W  packed read data.
- ReadPending  out  NUM_RD  per read port: addressed register has an outstanding pending write.
- PendSet  in  1  mark register PendAddress as pending (load issued).
- PendAddress  in  ADDR_W  register to mark.
- HiLoWrite  in  1  write HI and LO together.
- HiIn, LoIn  in  DATA_W each  HI/LO write data.
- HiOut, LoOut  out  DATA_W each  current HI/LO.

Behaviour:
- Reset: on a rising edge with rst=1, all NREGS registers, HI, LO and all pending bits become 0.
  - rst overrides every write, PendSet and HiLoWrite in the same cycle.
  - After reset: DataOut=0, ReadPending=0, HiOut=LoOut=0.
- Register 0:
  - Never written.
  - Its pending bit is never set.
  - Reads of address 0 always return 0 with ReadPending=0.
- Write:
  - At posedge, for each port k with RegWrite[k]=1 and WriteAddress[k]!=0, the register takes DataIn[k]. Latency 1 edge.
  - Two ports writing the same address in the same cycle: the highest-index port wins; the other is discarded silently.
- Read:
  - Purely combinational from ReadAddress; no clock latency.
  - Ports are fully independent; identical addresses on several ports are legal.
- Pending scoreboard (one bit per register):
  - Set at posedge when PendSet=1 and PendAddress!=0.
  - Cleared at posedge when any enabled write port targets that address.
  - PendSet and a write to the same address in the same cycle: set wins, and the written data is still stored (a younger load supersedes the older write).
  - PendSet on an already-pending register: stays pending, no error.
  - ReadPending[j] = pending bit of ReadAddress[j] (post-forwarding when bypass is compiled in; see below).
- HI/LO:
  - Both update at posedge when HiLoWrite=1.
  - No partial write.
  - Independent of the GPR ports.
- Mid-operation reset: pending state is lost. The pipeline flushes on rst, so no recovery is required.

Optional Feature:
- Macro: MIPS_RF_BYPASS_EN.
- Defined (write-to-read forwarding):
  - A read whose address matches an enabled, non-zero write address in the same cycle returns that port's DataIn (highest-index match) and ReadPending=0 for that port.
  - HiOut/LoOut return HiIn/LoIn when HiLoWrite=1.
  - rst=1 forces all forwarded values to 0.
- Undefined: reads return the pre-edge stored value; writes are visible on the cycle after the edge.

Decomposition:
- Shared package mips_rf_pkg:
  - Default width/depth localparams (DATA_W_DEF=32, ADDR_W_DEF=5).
  - Typedef reg_addr_t (ADDR_W bits) and reg_data_t.
  - Constant ZERO_REG = 0.
- One natural sub-module, mips_rf_scoreboard: pending-bit array with set/clear priority and per-port lookup. Reused later by the issue logic.
- Storage, write priority, HI/LO and forwarding stay in the top module.

Test Plan:
- Reset then read all addresses on all ports: every DataOut=0, ReadPending=0, HiOut=LoOut=0.
- NUM_WR=2, both ports write address 7 (port0 0xAAAA_0000, port1 0x5555_1234): next cycle reg7 reads 0x5555_1234.
- Write 0xDEAD_BEEF to address 0, PendSet to address 0: reg0 reads 0, ReadPending=0.
- PendSet addr 12, then read 12: ReadPending=1. Write 0x0000_0042 to 12: next cycle ReadPending=0, data 0x42. Repeat with simultaneous PendSet+write to 12: pending=1 and data stored.
- Without bypass: write 0x1111_1111 to reg 3 while reading 3 -> old value that cycle, new value next cycle. With MIPS_RF_BYPASS_EN: 0x1111_1111 the same cycle.
- HiLoWrite with HiIn=0x1, LoIn=0xFFFF_FFFE, asserted together with rst=1: HI/LO remain 0. Repeat without rst: HiOut=0x1, LoOut=0xFFFF_FFFE next cycle.
